// File: rtl/fir_mc_tdm.sv
// Time-multiplexed multi-channel FIR: one shared MAC, per-channel delay lines, shared runtime-loadable taps.
// Optional FIR_MC_SAT_EN: round-half-up and saturate the output; otherwise truncate and wrap.
module fir_mc_tdm #(
  parameter int N        = 49,
  parameter int C        = 4,
  parameter int W_in     = 16,
  parameter int W_in_F   = 14,
  parameter int W_coef   = 16,
  parameter int W_coef_F = 15,
  parameter int W_out    = 16,
  parameter int W_out_F  = 14
) (
  input  logic                                 clk,
  input  logic                                 resetn,
  input  logic                                 coef_we,
  input  logic [$clog2(N)-1:0]                 coef_addr,
  input  logic signed [W_coef-1:0]             coef_data,
  output logic                                 coef_busy,
  input  logic signed [W_in-1:0]               t_data_in,
  input  logic [((C > 1) ? $clog2(C) : 1)-1:0] t_chan_in,
  input  logic                                 t_valid_in,
  output logic                                 t_ready,
  output logic signed [W_out-1:0]              out_data,
  output logic [((C > 1) ? $clog2(C) : 1)-1:0] out_chan,
  output logic                                 out_valid,
  input  logic                                 out_ready
);

  localparam int NW = $clog2(N);
  localparam int CW = (C > 1) ? $clog2(C) : 1;
  localparam int PW = W_in + W_coef;
  localparam int AW = PW + $clog2(N);
  localparam int S  = W_in_F + W_coef_F - W_out_F;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

  state_t                          r_state;
  state_t                          w_next;
  logic                            w_take;
  logic                            w_chan_ok;
  logic [C-1:0][N-1:0][W_in-1:0]   r_x;
  logic [N-1:0][W_coef-1:0]        r_h;
  logic [CW-1:0]                   r_chan;
  logic [NW-1:0]                   r_tap;
  logic signed [AW-1:0]            r_acc;
  logic signed [PW-1:0]            w_prod;
  logic signed [W_out-1:0]         w_res;
  logic signed [W_out-1:0]         r_out_dat;
  logic [CW-1:0]                   r_out_chan;
  logic                            r_out_vld;
  logic                            r_t_ready;
  logic                            r_busy;

  assign w_chan_ok = 32'(t_chan_in) < C;
  assign w_prod    = $signed(r_x[r_chan][r_tap]) * $signed(r_h[r_tap]);

  always_comb begin
    w_next = r_state;
    w_take = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (t_valid_in && r_t_ready && w_chan_ok) begin
          w_take = 1'b1;
          w_next = S_MAC;
        end
      end
      S_MAC: begin
        if (32'(r_tap) == N - 1) w_next = S_OUT;
      end
      S_OUT: begin
        if (r_out_vld && out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

`ifdef FIR_MC_SAT_EN
  localparam int SM1 = (S > 0) ? S - 1 : 0;
  localparam logic signed [AW-1:0] RND  = (S > 0) ? AW'(64'sd1 <<< SM1) : '0;
  localparam logic signed [AW-1:0] MAXO = AW'((64'sd1 <<< (W_out - 1)) - 64'sd1);
  localparam logic signed [AW-1:0] MINO = ~MAXO;

  logic signed [AW-1:0] w_shift;
  assign w_shift = (r_acc + RND) >>> S;

  always_comb begin
    w_res = w_shift[W_out-1:0];
    if (w_shift > MAXO)      w_res = MAXO[W_out-1:0];
    else if (w_shift < MINO) w_res = MINO[W_out-1:0];
  end
`else
  assign w_res = W_out'(r_acc >>> S);
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_x        <= '0;
      r_h        <= '0;
      r_chan     <= '0;
      r_tap      <= '0;
      r_acc      <= '0;
      r_out_dat  <= '0;
      r_out_chan <= '0;
      r_out_vld  <= 1'b0;
      r_t_ready  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_t_ready <= (w_next == S_IDLE);
      r_busy    <= (w_next == S_MAC);
      // Taps are only writable while the MAC is idle; a write alongside an accept lands before tap 0.
      if (coef_we && !r_busy && 32'(coef_addr) < N) r_h[coef_addr] <= coef_data;
      if (w_take) begin
        r_x[t_chan_in] <= {r_x[t_chan_in][N-2:0], t_data_in};
        r_chan         <= t_chan_in;
        r_acc          <= '0;
        r_tap          <= '0;
      end
      if (r_state == S_MAC) begin
        r_acc <= r_acc + AW'(w_prod);
        r_tap <= r_tap + NW'(1);
      end
      if (r_state == S_OUT) begin
        if (!r_out_vld) begin
          r_out_dat  <= w_res;
          r_out_chan <= r_chan;
          r_out_vld  <= 1'b1;
        end else if (out_ready) begin
          r_out_vld <= 1'b0;
        end
      end
    end
  end

  assign coef_busy = r_busy;
  assign t_ready   = r_t_ready;
  assign out_data  = r_out_dat;
  assign out_chan  = r_out_chan;
  assign out_valid = r_out_vld;

endmodule
